// File: rtl/uarch_rst_ctrl_if.sv
// Flush handshake and per-channel drain signals between the fence.t
// micro-reset controller (master) and the cache/interface side (slave).
interface uarch_rst_ctrl_if #(
  parameter int NumChan = 2
);
  logic               flush_dcache_o;
  logic               flush_dcache_ack_i;
  logic [NumChan-1:0] busy_i;
  logic [NumChan-1:0] drain_mask_i;

  modport master (
    output flush_dcache_o,
    input  flush_dcache_ack_i,
    input  busy_i,
    input  drain_mask_i
  );

  modport slave (
    input  flush_dcache_o,
    output flush_dcache_ack_i,
    output busy_i,
    output drain_mask_i
  );
endinterface

// File: rtl/uarch_rst_ctrl.sv
// fence.t micro-reset controller: flush the dcache, drain the handshaked
// channels, pad until the selected time source expires, hold a
// microarchitectural reset, then resume at the instruction after the fence.
module uarch_rst_ctrl #(
  parameter int  NumChan       = 2,
  parameter int  NumSrc        = 2,
  parameter int  PadWidth      = 32,
  parameter int  DrainCycles   = 16,
  parameter int  RstCycles     = 16,
  parameter int  InitHold      = 3,
  parameter int  TimeoutCycles = 1024,
  parameter int  VLEN          = 64,
  localparam int SelW          = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fence_t_i,
  input  logic [VLEN-1:0]     pc_commit_i,
  input  logic [VLEN-1:0]     boot_addr_i,
  output logic [VLEN-1:0]     rst_addr_o,
  uarch_rst_ctrl_if.master    bus_if,
  input  logic [NumSrc-1:0]   pad_src_i,
  input  logic [SelW-1:0]     pad_sel_i,
  input  logic [PadWidth-1:0] pad_i,
  output logic [PadWidth-1:0] ceil_o,
  output logic                halt_o,
  output logic                stall_o,
  output logic                rst_uarch_no,
  output logic                cache_init_no,
  output logic                timeout_o
);
  localparam int DcW  = $clog2(DrainCycles + 1);
  localparam int TmoW = $clog2(TimeoutCycles);
  localparam int RcW  = (RstCycles > 1) ? $clog2(RstCycles) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_DRAIN = 3'd2,
    S_PAD   = 3'd3,
    S_RST   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [VLEN-1:0]       addr_q, addr_d;
  logic [PadWidth-1:0]   ceil_q, ceil_d;
  logic                  tmo_flag_q, tmo_flag_d;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [RcW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [DcW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [PadWidth-1:0]   pad_cnt_q, pad_cnt_d;
  logic [NumSrc-1:0]     src_q;
  logic [InitHold-1:0]   init_sr_q, init_sr_d;

  logic [NumChan-1:0]    live_s;
  logic [NumSrc-1:0]     rise_s;
  logic                  pad_load_s;
  logic                  drain_done_s;
  logic                  tmo_hit_s;
  logic                  to_pad_s;
  logic                  in_rst_s;
  logic [PadWidth-1:0]   ceil_load_s;

  assign live_s       = bus_if.busy_i & ~bus_if.drain_mask_i;
  assign drain_done_s = (drain_cnt_q == DcW'(DrainCycles));
  assign tmo_hit_s    = (tmo_cnt_q == TmoW'(TimeoutCycles - 1));
  assign in_rst_s     = (state_q == S_RST);
  // Padding already consumed since the last load; zero when the pad has run out.
  assign ceil_load_s  = (pad_cnt_q == {PadWidth{1'b0}}) ? {PadWidth{1'b0}} : (pad_i - pad_cnt_q);

  // cache_init_no stretch: remembers the last InitHold cycles of RST occupancy.
  if (InitHold > 1) begin : g_sr
    assign init_sr_d = {init_sr_q[InitHold-2:0], in_rst_s};
  end else begin : g_sr1
    assign init_sr_d = in_rst_s;
  end

  // Free-running counters: source edge select, pad countdown and drain idle count.
  always_comb begin
    rise_s     = pad_src_i & ~src_q;
    pad_load_s = rise_s[0];
    for (int i = 1; i < NumSrc; i++) begin
      pad_load_s = (pad_sel_i == SelW'(i)) ? rise_s[i] : pad_load_s;
    end
    if (pad_load_s) begin
      pad_cnt_d = pad_i;
    end else if (pad_cnt_q != {PadWidth{1'b0}}) begin
      pad_cnt_d = pad_cnt_q - PadWidth'(1'b1);
    end else begin
      pad_cnt_d = pad_cnt_q;
    end
    if (|live_s) begin
      drain_cnt_d = {DcW{1'b0}};
    end else if (!drain_done_s) begin
      drain_cnt_d = drain_cnt_q + DcW'(1'b1);
    end else begin
      drain_cnt_d = drain_cnt_q;
    end
  end

  // Sequencing FSM: next state, resume address, ceiling and timeout bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ceil_d     = ceil_q;
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = tmo_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    to_pad_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fence_t_i) begin
          addr_d     = pc_commit_i + VLEN'(3'd4);
          tmo_flag_d = 1'b0;
          tmo_cnt_d  = {TmoW{1'b0}};
          state_d    = S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1'b1);
        if (tmo_hit_s) begin
          to_pad_s = 1'b1;
        end else if (bus_if.flush_dcache_ack_i) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DRAIN: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1'b1);
        if (tmo_hit_s || drain_done_s) begin
          to_pad_s = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_PAD: begin
        // A load in the same cycle as an empty counter keeps us padding.
        if ((pad_cnt_q == {PadWidth{1'b0}}) && !pad_load_s) begin
          state_d = S_RST;
        end else begin
          state_d = S_PAD;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RcW'(RstCycles - 1)) begin
          state_d   = S_IDLE;
          rst_cnt_d = {RcW{1'b0}};
        end else begin
          rst_cnt_d = rst_cnt_q + RcW'(1'b1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        rst_cnt_d = {RcW{1'b0}};
      end
    endcase
    if (to_pad_s) begin
      state_d    = S_PAD;
      ceil_d     = ceil_load_s;
      tmo_flag_d = tmo_flag_q | tmo_hit_s;
    end else begin
      ceil_d = ceil_q;
    end
  end

  // State and counter registers; async reset returns to the boot/idle picture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= boot_addr_i;
      ceil_q      <= {PadWidth{1'b0}};
      tmo_flag_q  <= 1'b0;
      tmo_cnt_q   <= {TmoW{1'b0}};
      rst_cnt_q   <= {RcW{1'b0}};
      drain_cnt_q <= {DcW{1'b0}};
      pad_cnt_q   <= {PadWidth{1'b0}};
      src_q       <= {NumSrc{1'b0}};
      init_sr_q   <= {InitHold{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ceil_q      <= ceil_d;
      tmo_flag_q  <= tmo_flag_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      src_q       <= pad_src_i;
      init_sr_q   <= init_sr_d;
    end
  end

  assign rst_addr_o            = addr_q;
  assign ceil_o                = ceil_q;
  assign timeout_o             = tmo_flag_q;
  assign halt_o                = (state_q != S_IDLE);
  assign stall_o               = (state_q == S_DRAIN) || (state_q == S_PAD) || (state_q == S_RST);
  assign bus_if.flush_dcache_o = (state_q == S_FLUSH);
  assign rst_uarch_no          = ~in_rst_s;
  assign cache_init_no         = in_rst_s | (|init_sr_q);
endmodule

// File: tb/tb_uarch_rst_ctrl.sv
// Bench for uarch_rst_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a timestamp model.
module tb_uarch_rst_ctrl;
  localparam int NumChan = 2, NumSrc = 2, PadWidth = 32, DrainCycles = 16;
  localparam int RstCycles = 16, InitHold = 3, TimeoutCycles = 1024, VLEN = 64;
  localparam int M_IDLE = 0, M_FLUSH = 1, M_DRAIN = 2, M_PAD = 3, M_RST = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              fence_t_i;
  logic [VLEN-1:0]   pc_commit_i, boot_addr_i, rst_addr_o;
  logic [NumSrc-1:0] pad_src_i;
  logic [0:0]        pad_sel_i;
  logic [31:0]       pad_i, ceil_o;
  logic              halt_o, stall_o, rst_uarch_no, cache_init_no, timeout_o;

  uarch_rst_ctrl_if #(.NumChan(NumChan)) bus_if ();

  always #5 clk_i = ~clk_i;

  uarch_rst_ctrl #(
    .NumChan(NumChan), .NumSrc(NumSrc), .PadWidth(PadWidth), .DrainCycles(DrainCycles),
    .RstCycles(RstCycles), .InitHold(InitHold), .TimeoutCycles(TimeoutCycles), .VLEN(VLEN)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fence_t_i(fence_t_i), .pc_commit_i(pc_commit_i),
    .boot_addr_i(boot_addr_i), .rst_addr_o(rst_addr_o), .bus_if(bus_if),
    .pad_src_i(pad_src_i), .pad_sel_i(pad_sel_i), .pad_i(pad_i), .ceil_o(ceil_o),
    .halt_o(halt_o), .stall_o(stall_o), .rst_uarch_no(rst_uarch_no),
    .cache_init_no(cache_init_no), .timeout_o(timeout_o)
  );

  int n_tests, n_fail;
  longint cyc;
  int act_stall, act_rstlow;

  // Model: phase plus timestamps of the events that the rules depend on.
  int          m_st;
  logic [63:0] m_addr;
  logic [31:0] m_ceil;
  bit          m_tmo;
  longint      last_busy, pad_base, pad_val, fence_cyc, rst_enter, rst_exit;
  logic [1:0]  prev_src;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Remaining pad count at the current cycle, from the last load time.
  function automatic longint pad_now();
    longint r;
    r = pad_val - (cyc - pad_base);
    return (r > 0) ? r : 0;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_addr = boot_addr_i; m_ceil = 32'd0; m_tmo = 1'b0;
    last_busy = cyc - 1; pad_val = 0; pad_base = cyc;
    fence_cyc = cyc; rst_enter = cyc; rst_exit = cyc - 100; prev_src = 2'b00;
  endtask

  task automatic check_all();
    chk("rst_addr", rst_addr_o, m_addr);
    chk("ceil", ceil_o, m_ceil);
    chk("timeout", timeout_o, m_tmo);
    chk("halt", halt_o, m_st != M_IDLE);
    chk("stall", stall_o, m_st == M_DRAIN || m_st == M_PAD || m_st == M_RST);
    chk("flush", bus_if.flush_dcache_o, m_st == M_FLUSH);
    chk("rst_uarch_n", rst_uarch_no, m_st != M_RST);
    chk("cache_init_n", cache_init_no,
        (m_st == M_RST) || (cyc >= rst_exit && cyc - rst_exit < InitHold));
  endtask

  // Advance the model by one cycle using the inputs currently applied.
  task automatic model_step();
    longint pc; logic [31:0] pc32; bit tmo_hit, to_pad, load; int sel; logic [1:0] rise;
    pc = pad_now(); pc32 = pc[31:0];
    rise = pad_src_i & ~prev_src;
    sel = (int'(pad_sel_i) < NumSrc) ? int'(pad_sel_i) : 0;
    load = rise[sel];
    tmo_hit = ((cyc - fence_cyc - 1) == TimeoutCycles - 1);
    to_pad = 1'b0;
    case (m_st)
      M_IDLE: if (fence_t_i) begin
        m_addr = pc_commit_i + 64'd4; m_tmo = 1'b0; fence_cyc = cyc; m_st = M_FLUSH;
      end
      M_FLUSH: if (tmo_hit) to_pad = 1'b1; else if (bus_if.flush_dcache_ack_i) m_st = M_DRAIN;
      M_DRAIN: if (tmo_hit || (cyc - last_busy - 1) >= DrainCycles) to_pad = 1'b1;
      M_PAD: if (pc == 0 && !load) begin m_st = M_RST; rst_enter = cyc + 1; end
      M_RST: if (cyc - rst_enter == RstCycles - 1) begin m_st = M_IDLE; rst_exit = cyc + 1; end
      default: m_st = M_IDLE;
    endcase
    if (to_pad) begin
      m_st = M_PAD;
      m_ceil = (pc == 0) ? 32'd0 : pad_i - pc32;
      if (tmo_hit) m_tmo = 1'b1;
    end
    if (load) begin pad_val = pad_i; pad_base = cyc + 1; end
    prev_src = pad_src_i;
    if (|(bus_if.busy_i & ~bus_if.drain_mask_i)) last_busy = cyc;
  endtask

  task automatic tick();
    check_all();
    if (stall_o && rst_uarch_no) act_stall++;
    if (!rst_uarch_no) act_rstlow++;
    model_step();
    @(negedge clk_i);
    cyc++;
  endtask

  // Run until the sequence returns to IDLE, within a cycle budget.
  task automatic run_idle(input int bound);
    for (int i = 0; i < bound && halt_o; i++) tick();
    chk("idle_reached", halt_o, 1'b0);
  endtask

  task automatic fence(input logic [63:0] pc);
    fence_t_i = 1'b1; pc_commit_i = pc; tick(); fence_t_i = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_uarch_n", rst_uarch_no, 1'b1);
    chk("async_halt", halt_o, 1'b0);
    chk("async_rst_addr", rst_addr_o, 64'h1000);
    chk("async_cache_init_n", cache_init_no, 1'b0);
    @(negedge clk_i);
    cyc++;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic rand_inputs();
    fence_t_i = ($urandom_range(0, 9) == 0);
    pc_commit_i = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)}
                                               : {$urandom, $urandom};
    bus_if.flush_dcache_ack_i = ($urandom_range(0, 3) == 0);
    bus_if.busy_i = {($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0)};
    if ($urandom_range(0, 49) == 0) bus_if.drain_mask_i = 2'($urandom);
    if ($urandom_range(0, 5) == 0) pad_src_i[$urandom_range(0, 1)] ^= 1'b1;
    if ($urandom_range(0, 29) == 0) pad_sel_i = 1'($urandom);
    pad_i = $urandom_range(0, 30);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; act_stall = 0; act_rstlow = 0;
    rst_ni = 1'b0; fence_t_i = 1'b0; pc_commit_i = 64'd0; boot_addr_i = 64'h1000;
    bus_if.flush_dcache_ack_i = 1'b0; bus_if.busy_i = 2'b00; bus_if.drain_mask_i = 2'b00;
    pad_src_i = 2'b00; pad_sel_i = 1'b0; pad_i = 32'd100;
    @(negedge clk_i);
    model_reset();
    check_all();
    chk("reset_rst_addr", rst_addr_o, 64'h1000);
    chk("reset_rst_uarch_n", rst_uarch_no, 1'b1);
    chk("reset_ceil", ceil_o, 32'd0);
    @(negedge clk_i);
    cyc++;
    rst_ni = 1'b1;
    model_reset();

    // Basic sequence: edge 40 cycles before the fence, ack 5 cycles after it.
    for (int i = 0; i < 20; i++) tick();
    pad_src_i[0] = 1'b1;
    tick();
    for (int i = 0; i < 39; i++) tick();
    fence(64'h8000_0100);
    chk("basic_rst_addr", rst_addr_o, 64'h8000_0104);
    chk("basic_flush", bus_if.flush_dcache_o, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    bus_if.flush_dcache_ack_i = 1'b1; tick(); bus_if.flush_dcache_ack_i = 1'b0;
    act_rstlow = 0;
    run_idle(300);
    chk("basic_ceil", ceil_o, 32'd45);
    chk("basic_rst_low_cycles", act_rstlow, 16);
    chk("basic_cache_init_hold", cache_init_no, 1'b1);

    // Masked busy channel: drain completes 16 idle cycles after unmasking.
    for (int i = 0; i < 5; i++) tick();
    bus_if.busy_i = 2'b10;
    fence(64'h100);
    bus_if.drain_mask_i = 2'b10; bus_if.flush_dcache_ack_i = 1'b1; tick();
    bus_if.flush_dcache_ack_i = 1'b0;
    act_stall = 0;
    run_idle(300);
    chk("mask_drain_pad_cycles", act_stall, 17);
    chk("mask_no_timeout", timeout_o, 1'b0);

    // Unmasked stuck channel: forced exit by timeout, sticky until next fence.
    bus_if.drain_mask_i = 2'b00;
    fence(64'h200);
    bus_if.flush_dcache_ack_i = 1'b1; tick(); bus_if.flush_dcache_ack_i = 1'b0;
    run_idle(TimeoutCycles + 200);
    chk("timeout_sticky", timeout_o, 1'b1);
    bus_if.busy_i = 2'b00;
    fence(64'h300);
    chk("timeout_cleared", timeout_o, 1'b0);
    bus_if.flush_dcache_ack_i = 1'b1; tick(); bus_if.flush_dcache_ack_i = 1'b0;
    run_idle(300);

    // Pad source select: edges on unselected source 0 never load.
    pad_sel_i = 1'b1; pad_i = 32'd50;
    pad_src_i[0] = 1'b0; tick(); pad_src_i[0] = 1'b1; tick();
    fence(64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_rst_addr", rst_addr_o, 64'h2);
    bus_if.flush_dcache_ack_i = 1'b1; tick(); bus_if.flush_dcache_ack_i = 1'b0;
    run_idle(300);
    chk("unselected_ceil", ceil_o, 32'd0);

    // Selected source 1 edge during DRAIN with pad 8; fence during PAD ignored.
    pad_i = 32'd8;
    fence(64'h4000_0000);
    bus_if.flush_dcache_ack_i = 1'b1; tick(); bus_if.flush_dcache_ack_i = 1'b0;
    act_stall = 0;
    pad_src_i[1] = 1'b1; tick();
    tick(); tick();
    fence(64'h123);
    chk("ignored_fence_addr", rst_addr_o, 64'h4000_0004);
    run_idle(300);
    chk("sel1_drain_pad_cycles", act_stall, 10);

    // Reset mid-RST.
    fence(64'h500);
    bus_if.flush_dcache_ack_i = 1'b1; tick(); bus_if.flush_dcache_ack_i = 1'b0;
    for (int i = 0; i < 300 && rst_uarch_no; i++) tick();
    chk("reached_rst", rst_uarch_no, 1'b0);
    tick(); tick();
    apply_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      rand_inputs();
      tick();
      if (i == 4000) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
